uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
//
// PURPOSE
//   Serialises bytes onto a UART TX line, 8N1 framing, LSB first; transmit-side counterpart of
//   uart_receiver. Sits between a byte producer (CPU/debug/loopback logic) and the board TX pin.
//   Byte interface is a valid/ready handshake; the block buffers nothing beyond the frame in flight.
//
// PARAMETERS
//   CLOCK_RATE  25_000_000  clk frequency in Hz
//   BAUD_RATE   115200      line rate in bits/s; BitPeriod P = CLOCK_RATE / BAUD_RATE (integer, truncated)
//
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   reset_n     in   1  asynchronous, active-low reset
//   data        in   8  byte to send; sampled only on acceptance
//   data_valid  in   1  producer has a byte on data
//   ready       out  1  transmitter can accept a byte this cycle
//   uart_tx     out  1  serial line, idle high
//
// BEHAVIOUR
//   - Reset (reset_n low, async): uart_tx=1, ready=1, state=Idle, timer=0, bit index=0; any frame in
//     flight is abandoned immediately (line returns high mid-bit). All outputs registered.
//   - Elaboration: $error if P < 2. Timer width $clog2(P)+1; timer counts 0..P-1, then wraps to 0.
//   - Acceptance: data_valid && ready at a posedge. data latched into shift register at that edge;
//     uart_tx goes 0 (start bit) from that same edge -> latency 1 clk from accepting cycle to start bit.
//   - data_valid while ready=0 is ignored (not queued); changes on data after acceptance do not
//     affect the frame in flight.
//   - FSM: Idle -> Start -> Data -> Stop -> Idle.
//       Idle : uart_tx=1, ready=1; on acceptance -> Start.
//       Start: uart_tx=0 for exactly P clks -> Data.
//       Data : data[0]..data[7] each for exactly P clks; after bit 7 -> Stop (or Parity, see below).
//       Stop : uart_tx=1 for exactly P clks. ready=1 during the final clk of Stop only.
//              Acceptance in that clk -> Start with no gap; otherwise -> Idle.
//   - Isolated frame: ready low for 10*P-1 clks. Back-to-back frames with data_valid held: frame
//     pitch exactly 10*P clks, no idle bit between stop and next start.
//   - Every bit period is exactly P clks; no cumulative drift within or across frames.
//   - Release of reset_n: first acceptance possible on the first posedge after release.
//
// CONFIGURATION
//   UART_TX_PARITY_EN defined: even-parity bit (XOR of data[7:0]) inserted after data[7], held P clks,
//     FSM Data -> Parity -> Stop; frame 11 bits, ready low 11*P-1 clks, back-to-back pitch 11*P clks.
//   UART_TX_PARITY_EN undefined (default): plain 8N1 as above; no Parity state exists in the RTL.
//
// TESTING  (CLOCK_RATE=25_000_000, BAUD_RATE=115200 -> P=217 unless noted)
//   1. Hold reset_n low 5 clks, release -> uart_tx=1, ready=1; no transitions on uart_tx for 3000 clks.
//   2. Send 0xA5 once -> uart_tx = 0,1,0,1,0,0,1,0,1,1 each exactly 217 clks; ready low 2169 clks.
//   3. data_valid held, data 0x00 then 0xFF -> second start bit begins on the clk after first stop
//      bit ends; start-to-start spacing 2170 clks.
//   4. Loopback into uart_receiver (same params): 0x00,0x55,0xAA,0xFF,0x01,0x80 -> identical bytes out.
//   5. Pulse data_valid with 0x3C mid-frame of 0xC3, and change data mid-frame -> only 0xC3 on line,
//      unaltered; 0x3C never sent.
//   6. Assert reset_n low during data bit 4 -> uart_tx=1 and ready=1 same clk (async); next byte 0x5A
//      after release transmits correctly. With UART_TX_PARITY_EN: 0xA5 -> parity bit 0; 0x01 -> parity 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with a valid/ready byte interface.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data[7].
module uart_transmitter #(
  parameter int CLOCK_RATE = 25_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       uart_tx
);

  localparam int P  = CLOCK_RATE / BAUD_RATE;
  localparam int TW = $clog2(P) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(P - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(P - 2);

  generate
    if (P < 2) begin : g_bad_period
      $error("uart_transmitter: bit period CLOCK_RATE/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic accept;
  logic bit_end;

  assign accept  = data_valid && ready;
  assign bit_end = (timer == T_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (accept) begin
            shift   <= data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
            state   <= S_START;
            uart_tx <= 1'b0;
            ready   <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            uart_tx <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_tx <= parity_bit;
              state   <= S_PARITY;
`else
              uart_tx <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              uart_tx <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            timer   <= '0;
            uart_tx <= 1'b1;
            state   <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif

        S_STOP: begin
          // ready rises for the last clk of the stop bit so a waiting byte follows with no gap
          if (bit_end) begin
            timer <= '0;
            if (accept) begin
              shift   <= data;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^data;
`endif
              state   <= S_START;
              uart_tx <= 1'b0;
              ready   <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
            if (timer == T_PRE) begin
              ready <= 1'b1;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          timer   <= '0;
          uart_tx <= 1'b1;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter against a frame-level model.
module tb_uart_transmitter;

  localparam int CLOCK_RATE = 25_000_000;
  localparam int BAUD_RATE  = 115200;
  localparam int P          = CLOCK_RATE / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data      (data),
    .data_valid(data_valid),
    .ready     (ready),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of frame bit k: start, data LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NB == 11 && k == 9) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || ready !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic start_frame(input string tag, input logic [7:0] d);
    @(negedge clk);
    check({tag, " ready before accept"}, ready, 1);
    data = d;
    data_valid = 1'b1;
    @(posedge clk);
  endtask

  // Follows one frame whose acceptance edge has just passed.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic next_valid,
                             input logic [7:0] next_data, input int pulse_at);
    int bad_tx;
    int bad_rdy;
    int idx;
    logic [7:0] got;
    bad_rdy = 0;
    got = 8'h00;
    for (int k = 0; k < NB; k++) begin
      bad_tx = 0;
      for (int c = 0; c < P; c++) begin
        @(negedge clk);
        if (uart_tx !== exp_bit(d, k)) bad_tx++;
        if (ready !== ((k == NB - 1) && (c == P - 1))) bad_rdy++;
        if (c == P / 2 && k >= 1 && k <= 8) got[k-1] = uart_tx;
        idx = k * P + c;
        if (idx == 0) begin
          data = next_data;
          data_valid = next_valid;
        end
        if (pulse_at >= 0 && idx == pulse_at) begin
          data = 8'h3C;
          data_valid = 1'b1;
        end else if (pulse_at >= 0 && idx == pulse_at + 1) begin
          data = 8'h99;
          data_valid = 1'b0;
        end
      end
      check($sformatf("%s bit%0d", tag, k), bad_tx, 0);
    end
    check({tag, " ready"}, bad_rdy, 0);
    check({tag, " decoded byte"}, got, d);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] r;

    // reset and quiet line
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset tx", uart_tx, 1);
    check("reset ready", ready, 1);
    reset_n = 1'b1;
    check_idle("idle after reset", 3000);

    // isolated frame
    start_frame("a5", 8'hA5);
    check_frame("a5", 8'hA5, 1'b0, 8'h00, -1);
    check_idle("idle after a5", 5);

    // back-to-back with data_valid held
    start_frame("b2b", 8'h00);
    check_frame("b2b 00", 8'h00, 1'b1, 8'hFF, -1);
    check_frame("b2b ff", 8'hFF, 1'b0, 8'h00, -1);

    // directed pattern list followed by random bytes, all back-to-back
    q = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h01, 8'h80};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
    start_frame("stream", q[0]);
    for (int i = 0; i < q.size(); i++) begin
      check_frame($sformatf("stream%0d", i), q[i], (i < q.size() - 1),
                  (i < q.size() - 1) ? q[i+1] : 8'h00, -1);
    end

    // mid-frame valid pulse and data change are ignored
    start_frame("c3", 8'hC3);
    check_frame("c3", 8'hC3, 1'b0, 8'h00, 3 * P + 20);
    check_idle("no 3c frame", 3 * P);

    // async reset during data bit 4
    r = 8'($urandom_range(0, 255));
    start_frame("abort", r);
    data_valid = 1'b0;
    for (int i = 0; i < 5 * P + P / 2; i++) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async reset tx", uart_tx, 1);
    check("async reset ready", ready, 1);
    repeat (3) @(negedge clk);
    check("reset held tx", uart_tx, 1);
    reset_n = 1'b1;
    data = 8'h5A;
    data_valid = 1'b1;
    @(posedge clk);
    check_frame("5a after reset", 8'h5A, 1'b0, 8'h00, -1);

`ifdef UART_TX_PARITY_EN
    start_frame("par01", 8'h01);
    check_frame("par01", 8'h01, 1'b0, 8'h00, -1);
`endif

    check_idle("final idle", 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
